// File: rtl/fccc_clken_gen.sv
// rtl/fccc_clken_gen.sv - lock-qualified multi-channel clock-enable generator on FCCC GL0
// Optional feature: define FCCC_LOCK_LOSS_CNT_EN to add the saturating LOSS_CNT output.
module fccc_clken_gen #(
    parameter int NUM_CH             = 4,
    parameter int DIV_W              = 8,
    parameter int LOCK_STABLE_CYCLES = 256
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      LOCK,
    input  logic [NUM_CH*DIV_W-1:0]   DIV_RATIO,
    output logic [NUM_CH-1:0]         CLK_EN,
    output logic                      LOCK_OK,
    output logic [1:0]                STATE
`ifdef FCCC_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]                LOSS_CNT
`endif
);

    localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t            state_q;
    logic              sync1_q;
    logic              lock_s_q;
    logic [SW-1:0]     stab_cnt_q;
    logic [NUM_CH-1:0] clk_en_q;

    logic [DIV_W-1:0]  ratio_in [NUM_CH];
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W-1:0]  ratio_q  [NUM_CH];
    logic [DIV_W-1:0]  ratio_d  [NUM_CH];
    logic [NUM_CH-1:0] en_d;
    logic [NUM_CH-1:0] entry_en;

`ifdef FCCC_LOCK_LOSS_CNT_EN
    logic [7:0]        loss_cnt_q;
`endif

    // Ratios 0 and 1 both mean "every cycle", so they count as last-of-period always.
    function automatic logic at_last(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] r);
        return (r <= DIV_W'(1)) || (c == r - DIV_W'(1));
    endfunction

    always_comb begin
        en_d     = '0;
        entry_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ratio_in[i] = DIV_RATIO[i*DIV_W +: DIV_W];
            entry_en[i] = at_last('0, ratio_in[i]);
            // A new ratio is only taken at a period boundary, so periods are never cut short.
            if (at_last(cnt_q[i], ratio_q[i])) begin
                cnt_d[i]   = '0;
                ratio_d[i] = ratio_in[i];
            end else begin
                cnt_d[i]   = cnt_q[i] + DIV_W'(1);
                ratio_d[i] = ratio_q[i];
            end
            en_d[i] = at_last(cnt_d[i], ratio_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_WAIT_LOCK;
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
            stab_cnt_q <= '0;
            clk_en_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                ratio_q[i] <= '0;
            end
`ifdef FCCC_LOCK_LOSS_CNT_EN
            loss_cnt_q <= '0;
`endif
        end else begin
            sync1_q  <= LOCK;
            lock_s_q <= sync1_q;
            case (state_q)
                ST_WAIT_LOCK: begin
                    stab_cnt_q <= '0;
                    clk_en_q   <= '0;
                    if (lock_s_q) begin
                        state_q <= ST_STABILIZE;
                    end
                end
                ST_STABILIZE: begin
                    clk_en_q <= '0;
                    if (!lock_s_q) begin
                        state_q    <= ST_WAIT_LOCK;
                        stab_cnt_q <= '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        // Entering RUN: every channel restarts together, giving phase alignment.
                        state_q    <= ST_RUN;
                        stab_cnt_q <= '0;
                        clk_en_q   <= entry_en;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_q[i]   <= '0;
                            ratio_q[i] <= ratio_in[i];
                        end
                    end else begin
                        stab_cnt_q <= stab_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_q  <= ST_WAIT_LOCK;
                        clk_en_q <= '0;
`ifdef FCCC_LOCK_LOSS_CNT_EN
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_q <= loss_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        clk_en_q <= en_d;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_q[i]   <= cnt_d[i];
                            ratio_q[i] <= ratio_d[i];
                        end
                    end
                end
                default: begin
                    state_q  <= ST_WAIT_LOCK;
                    clk_en_q <= '0;
                end
            endcase
        end
    end

    assign CLK_EN  = clk_en_q;
    assign LOCK_OK = (state_q == ST_RUN);
    assign STATE   = state_q;
`ifdef FCCC_LOCK_LOSS_CNT_EN
    assign LOSS_CNT = loss_cnt_q;
`endif

endmodule

// File: tb/tb_fccc_clken_gen.sv
// tb/tb_fccc_clken_gen.sv - randomized model-checked bench for fccc_clken_gen
module tb_fccc_clken_gen;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int LSC = 16;

    logic               clk;
    logic               reset;
    logic               lock;
    logic [NCH*DW-1:0]  div_ratio;
    logic [NCH-1:0]     clk_en;
    logic               lock_ok;
    logic [1:0]         state;
`ifdef FCCC_LOCK_LOSS_CNT_EN
    logic [7:0]         loss_cnt;
`endif

    fccc_clken_gen #(
        .NUM_CH(NCH), .DIV_W(DW), .LOCK_STABLE_CYCLES(LSC)
    ) dut (
        .CLK(clk), .RESET(reset), .LOCK(lock), .DIV_RATIO(div_ratio),
        .CLK_EN(clk_en), .LOCK_OK(lock_ok), .STATE(state)
`ifdef FCCC_LOCK_LOSS_CNT_EN
        , .LOSS_CNT(loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // Model: LOCK as seen by the FSM is LOCK two edges back; lock is qualified once
    // LSC+1 consecutive high observations accumulate. Channels use countdowns to the next pulse.
    bit          m_valid = 0;
    int          m_run = 0, m_blank = 0, m_loss = 0;
    bit          m_d1 = 0, m_d2 = 0;
    int          m_rem [NCH];
    logic [1:0]  exp_state;
    logic [NCH-1:0] exp_en;

    function automatic int eff(input int r);
        return (r <= 1) ? 1 : r;
    endfunction

    always @(posedge clk) begin
        bit obs, was_run;
        if (reset) begin
            m_valid = 1; m_run = 0; m_blank = 2; m_loss = 0;
            for (int i = 0; i < NCH; i++) m_rem[i] = 0;
        end else begin
            obs = (m_blank > 0) ? 1'b0 : m_d2;
            if (m_blank > 0) m_blank--;
            was_run = (m_run > LSC);
            if (obs) m_run = was_run ? m_run : m_run + 1;
            else begin
                if (was_run && m_loss < 255) m_loss++;
                m_run = 0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (m_run > LSC && !was_run) m_rem[i] = eff(int'(div_ratio[i*DW +: DW])) - 1;
                else if (m_run > LSC)
                    m_rem[i] = (m_rem[i] == 0) ? eff(int'(div_ratio[i*DW +: DW])) - 1 : m_rem[i] - 1;
            end
        end
        m_d2 = m_d1;
        m_d1 = lock;
        exp_state = (m_run == 0) ? 2'd0 : (m_run <= LSC) ? 2'd1 : 2'd2;
        for (int i = 0; i < NCH; i++) exp_en[i] = (exp_state == 2'd2) && (m_rem[i] == 0);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_state", state, exp_state);
            chk("model_lock_ok", lock_ok, exp_state == 2'd2);
            chk("model_clk_en", clk_en, exp_en);
`ifdef FCCC_LOCK_LOSS_CNT_EN
            chk("model_loss_cnt", loss_cnt, m_loss);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_pulse(input int ch, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!clk_en[ch] && n < 40);
        if (!clk_en[ch]) chk("pulse_timeout", 0, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; lock = 1'b0;
        div_ratio = {8'd1, 8'd2, 8'd3, 8'd4};
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("reset_state", state, 0);
        chk("reset_lock_ok", lock_ok, 0);
        chk("reset_clk_en", clk_en, 0);

        // Lock rise: qualified at edge LSC+3, channels aligned
        lock = 1'b1;
        tick(18); chk("t1_lock_ok_e18", lock_ok, 0);
        tick(1);  chk("t1_lock_ok_e19", lock_ok, 1); chk("t1_en_c0", clk_en, 4'b1000);
        tick(1);  chk("t1_en_c1", clk_en, 4'b1100);
        tick(1);  chk("t1_en_c2", clk_en, 4'b1010);
        tick(1);  chk("t1_en_c3", clk_en, 4'b1101);
        tick(20);

        // Loss of lock in RUN
        lock = 1'b0;
        tick(2); chk("t3_lock_ok_e2", lock_ok, 1);
        tick(1); chk("t3_lock_ok_e3", lock_ok, 0); chk("t3_en_e3", clk_en, 0); chk("t3_state", state, 0);
`ifdef FCCC_LOCK_LOSS_CNT_EN
        chk("t3_loss_cnt", loss_cnt, 1);
`endif
        lock = 1'b1;
        tick(18); chk("t3_relock_e18", lock_ok, 0);
        tick(1);  chk("t3_relock_e19", lock_ok, 1); chk("t3_realign", clk_en, 4'b1000);
        tick(10);

        // One-cycle dropout during STABILIZE
        lock = 1'b0; tick(5);
        lock = 1'b1; tick(10);
        lock = 1'b0; tick(1);
        lock = 1'b1; tick(2);
        chk("t2_state_wait", state, 0);
        tick(16); chk("t2_lock_ok_e29", lock_ok, 0);
        tick(1);  chk("t2_lock_ok_e30", lock_ok, 1);

        // Ratio change mid-period takes effect at the next period
        div_ratio[7:0] = 8'd8;
        wait_pulse(0, n);
        wait_pulse(0, n); chk("t4_gap_8a", n, 8);
        tick(2);
        div_ratio[7:0] = 8'd3;
        wait_pulse(0, n); chk("t4_gap_8b", n + 2, 8);
        wait_pulse(0, n); chk("t4_gap_3a", n, 3);
        wait_pulse(0, n); chk("t4_gap_3b", n, 3);

        // Reset mid-RUN
        reset = 1'b1; tick(1);
        chk("t5_state", state, 0); chk("t5_lock_ok", lock_ok, 0); chk("t5_en", clk_en, 0);
`ifdef FCCC_LOCK_LOSS_CNT_EN
        chk("t5_loss_cnt", loss_cnt, 0);
`endif
        reset = 1'b0;
        tick(30);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (lock) lock = ($urandom_range(0, 99) != 0);
            else      lock = ($urandom_range(0, 3) == 0);
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 15) == 0) div_ratio[ch*DW +: DW] = 8'($urandom_range(0, 9));
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 1'b0;

`ifdef FCCC_LOCK_LOSS_CNT_EN
        reset = 1'b1; tick(1); reset = 1'b0;
        for (int k = 0; k < 300; k++) begin
            lock = 1'b1; tick(LSC + 4);
            lock = 1'b0; tick(4);
        end
        chk("t6_loss_sat", loss_cnt, 255);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
